// File: rtl/pipe_skid_reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared definitions for the decode->execute skid register:
//                occupancy state encoding, control-bundle bit positions and
//                funct3 branch encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  // Occupancy state; the encoded value equals the number of held entries.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  // Control bundle layout: funct3 in the low bits, then jump and branch,
  // so the smallest legal bundle is 5 bits wide.
  localparam int CTRL_FUNCT3_LSB = 0;
  localparam int CTRL_JUMP_BIT   = 3;
  localparam int CTRL_BRANCH_BIT = 4;

  // Conditional-branch funct3 encodings.
  localparam logic [2:0] c_FUNCT3_BEQ  = 3'b000;
  localparam logic [2:0] c_FUNCT3_BNE  = 3'b001;
  localparam logic [2:0] c_FUNCT3_BLT  = 3'b100;
  localparam logic [2:0] c_FUNCT3_BGE  = 3'b101;
  localparam logic [2:0] c_FUNCT3_BLTU = 3'b110;
  localparam logic [2:0] c_FUNCT3_BGEU = 3'b111;

endpackage
`default_nettype wire

// File: rtl/pipe_skid_reg_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_skid_reg_if
//  Description : Valid/ready handshake bundle around the skid register:
//                upstream (in_*) and downstream (out_*) channels.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipe_skid_reg_if #(
  parameter int DATA_W = 160,
  parameter int CTRL_W = 16
) ();

  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;

  // Environment side: drives the upstream entry, consumes the head.
  modport master (
    output in_valid, in_ctrl, in_data, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data
  );

  // Stage side: accepts upstream entries, presents the head.
  modport slave (
    input  in_valid, in_ctrl, in_data, out_ready,
    output in_ready, out_valid, out_ctrl, out_data
  );

endinterface
`default_nettype wire

// File: rtl/pipe_skid_reg_branch_cond.sv
`default_nettype none
// ============================================================================
//  Module      : branch_cond
//  Description : Combinational branch-taken decision from funct3 and the
//                ALU compare flags. Non-branch encodings never take.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_cond
  import pipe_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       lt,
  input  logic       ltu,
  output logic       take
);

  // Select the flag (or its inverse) that the branch type tests.
  always_comb begin
    take = 1'b0;
    case (funct3)
      c_FUNCT3_BEQ:  take = zero;
      c_FUNCT3_BNE:  take = ~zero;
      c_FUNCT3_BLT:  take = lt;
      c_FUNCT3_BGE:  take = ~lt;
      c_FUNCT3_BLTU: take = ltu;
      c_FUNCT3_BGEU: take = ~ltu;
      default:       take = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/pipe_skid_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_skid_reg
//  Description : Two-entry decode->execute skid register (main + skid) with
//                registered in_ready, flush bubble insertion and branch/jump
//                redirect (pc_src) computed from the head entry.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = 160,
  parameter int CTRL_W = 16   // must be >= 5 to hold funct3, jump, branch
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  pipe_skid_reg_if.slave     bus,
  input  logic               zero_e,
  input  logic               lt_e,
  input  logic               ltu_e,
  output logic               pc_src,
  output logic [1:0]         occupancy
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic              r_in_ready;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_main_data;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [DATA_W-1:0] r_skid_data;

  logic              w_out_valid;
  logic [1:0]        w_occupancy;
  logic              w_in_fire;
  logic              w_out_fire;
  logic              w_main_from_in;
  logic              w_main_from_skid;
  logic              w_skid_from_in;
  logic              w_take;

  assign w_in_fire  = bus.in_valid & r_in_ready;
  assign w_out_fire = w_out_valid & bus.out_ready;

  // State register; reset dominates everything else.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_EMPTY;
    else     r_state <= w_state_nxt;
  end

  // Next occupancy state: flush empties the stage, otherwise follow handshakes.
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: if (w_in_fire) w_state_nxt = ST_ONE;
        ST_ONE: begin
          if (w_in_fire && !w_out_fire)      w_state_nxt = ST_FULL;
          else if (!w_in_fire && w_out_fire) w_state_nxt = ST_EMPTY;
        end
        ST_FULL:  if (w_out_fire) w_state_nxt = ST_ONE;
        default:  w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  // State-decoded outputs and entry-load strobes (loads suppressed on flush).
  always_comb begin
    w_out_valid      = 1'b0;
    w_occupancy      = 2'd0;
    w_main_from_in   = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_from_in   = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        w_main_from_in = w_in_fire & ~flush;
      end
      ST_ONE: begin
        w_out_valid    = 1'b1;
        w_occupancy    = 2'd1;
        w_main_from_in = w_in_fire & w_out_fire & ~flush;
        w_skid_from_in = w_in_fire & ~w_out_fire & ~flush;
      end
      ST_FULL: begin
        w_out_valid      = 1'b1;
        w_occupancy      = 2'd2;
        w_main_from_skid = w_out_fire & ~flush;
      end
      default: begin
        w_out_valid = 1'b0;
      end
    endcase
  end

  // in_ready is registered so it carries no combinational path from out_ready.
  always_ff @(posedge clk) begin
    if (rst) r_in_ready <= 1'b1;
    else     r_in_ready <= (w_state_nxt != ST_FULL);
  end

  // Entry storage: flush zeroes control only, payload is left in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_main_ctrl <= '0;
      r_main_data <= '0;
      r_skid_ctrl <= '0;
      r_skid_data <= '0;
    end else if (flush) begin
      r_main_ctrl <= '0;
      r_skid_ctrl <= '0;
    end else begin
      if (w_main_from_in) begin
        r_main_ctrl <= bus.in_ctrl;
        r_main_data <= bus.in_data;
      end else if (w_main_from_skid) begin
        r_main_ctrl <= r_skid_ctrl;
        r_main_data <= r_skid_data;
      end
      if (w_skid_from_in) begin
        r_skid_ctrl <= bus.in_ctrl;
        r_skid_data <= bus.in_data;
      end
    end
  end

  branch_cond u_branch_cond (
    .funct3 (r_main_ctrl[CTRL_FUNCT3_LSB +: 3]),
    .zero   (zero_e),
    .lt     (lt_e),
    .ltu    (ltu_e),
    .take   (w_take)
  );

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_ctrl  = r_main_ctrl;
  assign bus.out_data  = r_main_data;
  assign occupancy     = w_occupancy;

  // Redirect only for a live head; stale control in an empty stage is ignored.
  assign pc_src = w_out_valid &
                  (r_main_ctrl[CTRL_JUMP_BIT] | (r_main_ctrl[CTRL_BRANCH_BIT] & w_take));

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_skid_reg
//  Description : Self-checking bench for pipe_skid_reg: directed scenarios
//                plus a randomized stream against a queue-based model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_skid_reg;
  import pipe_pkg::*;

  localparam int DATA_W = 160;
  localparam int CTRL_W = 16;

  typedef struct packed {
    logic [CTRL_W-1:0] c;
    logic [DATA_W-1:0] d;
  } ent_t;

  logic       clk;
  logic       rst;
  logic       flush;
  logic       zero_e;
  logic       lt_e;
  logic       ltu_e;
  logic       pc_src;
  logic [1:0] occupancy;

  pipe_skid_reg_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) bus ();

  pipe_skid_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .bus       (bus),
    .zero_e    (zero_e),
    .lt_e      (lt_e),
    .ltu_e     (ltu_e),
    .pc_src    (pc_src),
    .occupancy (occupancy)
  );

  ent_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_in     = 0;
  int   n_dut_out = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Expected redirect, straight from the branch rules on the model head.
  function automatic logic model_pc_src();
    logic [CTRL_W-1:0] c;
    logic              take;
    if (q.size() == 0) return 1'b0;
    c = q[0].c;
    case (c[CTRL_FUNCT3_LSB +: 3])
      3'b000:  take = zero_e;
      3'b001:  take = !zero_e;
      3'b100:  take = lt_e;
      3'b101:  take = !lt_e;
      3'b110:  take = ltu_e;
      3'b111:  take = !ltu_e;
      default: take = 1'b0;
    endcase
    return c[CTRL_JUMP_BIT] | (c[CTRL_BRANCH_BIT] & take);
  endfunction

  function automatic logic [CTRL_W-1:0] mkctrl(input logic j, input logic b, input logic [2:0] f3);
    logic [CTRL_W-1:0] c;
    c = CTRL_W'($urandom());
    c[CTRL_JUMP_BIT]           = j;
    c[CTRL_BRANCH_BIT]         = b;
    c[CTRL_FUNCT3_LSB +: 3]    = f3;
    return c;
  endfunction

  function automatic logic [DATA_W-1:0] rnd_data();
    logic [DATA_W-1:0] d;
    for (int i = 0; i < DATA_W / 32; i++) d[i*32 +: 32] = $urandom();
    return d;
  endfunction

  task automatic drive(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d);
    bus.in_valid = v;
    bus.in_ctrl  = c;
    bus.in_data  = d;
  endtask

  // One clock: the model is a 2-deep FIFO (pop before push), emptied by rst/flush.
  task automatic step();
    logic outf, inf, dutf;
    ent_t e;
    outf = (q.size() > 0) && bus.out_ready;
    inf  = bus.in_valid && (q.size() < 2);
    dutf = bus.out_valid && bus.out_ready;
    e.c  = bus.in_ctrl;
    e.d  = bus.in_data;
    @(posedge clk);
    if (dutf && !rst) n_dut_out++;
    if (rst || flush) begin
      q.delete();
    end else begin
      if (outf) void'(q.pop_front());
      if (inf) begin
        q.push_back(e);
        n_in++;
      end
    end
    #1;
  endtask

  task automatic check_all();
    chk("out_valid", bus.out_valid, q.size() != 0);
    chk("occupancy", occupancy, q.size());
    chk("in_ready", bus.in_ready, q.size() < 2);
    chk("pc_src", pc_src, model_pc_src());
    if (q.size() > 0) begin
      chk("out_data", bus.out_data, q[0].d);
      chk("out_ctrl", bus.out_ctrl, q[0].c);
    end
  endtask

  logic [CTRL_W-1:0] a_c, b_c, c_c;
  logic [DATA_W-1:0] a_d, b_d, c_d;

  initial begin
    rst = 1'b1; flush = 1'b0;
    zero_e = 1'b0; lt_e = 1'b0; ltu_e = 1'b0;
    drive(1'b0, '0, '0);
    bus.out_ready = 1'b0;
    step(); step();

    // Reset state
    check_all();
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_ctrl", bus.out_ctrl, 0);

    // First entry appears one cycle after acceptance
    rst = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b1, '0, DATA_W'(32'h1000));
    step();
    drive(1'b0, '0, '0);
    chk("first_valid", bus.out_valid, 1);
    chk("first_data", bus.out_data, 'h1000);
    chk("first_occ", occupancy, 1);
    check_all();
    step();
    check_all();

    // Fill with A, B under stall, then drain in order
    a_c = mkctrl(1'b0, 1'b0, 3'b010); a_d = rnd_data();
    b_c = mkctrl(1'b0, 1'b0, 3'b011); b_d = rnd_data();
    bus.out_ready = 1'b0;
    drive(1'b1, a_c, a_d); step(); check_all();
    drive(1'b1, b_c, b_d); step();
    drive(1'b0, '0, '0);
    chk("full_occ", occupancy, 2);
    chk("full_in_ready", bus.in_ready, 0);
    chk("full_head_a", bus.out_data, a_d);
    check_all();
    bus.out_ready = 1'b1;
    step();
    chk("drain_head_b", bus.out_data, b_d);
    chk("drain_in_ready", bus.in_ready, 1);
    check_all();
    step();
    chk("drain_empty", bus.out_valid, 0);
    check_all();

    // Full throughput: occupancy stays at one
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, mkctrl(1'b0, 1'b0, 3'($urandom())), rnd_data());
      step();
      chk("thru_occ", occupancy, 1);
      check_all();
    end
    drive(1'b0, '0, '0);
    step();
    check_all();

    // Flush while full with a simultaneous input
    a_c = mkctrl(1'b1, 1'b1, 3'b000); a_d = rnd_data();
    b_c = mkctrl(1'b1, 1'b0, 3'b001); b_d = rnd_data();
    c_c = mkctrl(1'b1, 1'b1, 3'b100); c_d = rnd_data();
    bus.out_ready = 1'b0;
    drive(1'b1, a_c, a_d); step();
    drive(1'b1, b_c, b_d); step();
    check_all();
    flush = 1'b1;
    drive(1'b1, c_c, c_d);
    step();
    flush = 1'b0;
    drive(1'b0, '0, '0);
    chk("flush_occ", occupancy, 0);
    chk("flush_valid", bus.out_valid, 0);
    chk("flush_ctrl", bus.out_ctrl, 0);
    chk("flush_in_ready", bus.in_ready, 1);
    chk("flush_data_held", bus.out_data, a_d);
    check_all();
    bus.out_ready = 1'b1;
    step(); check_all();
    step(); check_all();

    // Branch decision on the head entry
    bus.out_ready = 1'b0;
    drive(1'b1, mkctrl(1'b0, 1'b1, 3'b101), rnd_data());
    step();
    drive(1'b0, '0, '0);
    lt_e = 1'b0; #1;
    chk("bge_lt0", pc_src, 1);
    check_all();
    lt_e = 1'b1; #1;
    chk("bge_lt1", pc_src, 0);
    bus.out_ready = 1'b1;
    drive(1'b1, mkctrl(1'b0, 1'b1, 3'b010), rnd_data());
    step();
    bus.out_ready = 1'b0;
    drive(1'b0, '0, '0);
    for (int f = 0; f < 8; f++) begin
      {zero_e, lt_e, ltu_e} = 3'(f);
      #1;
      chk("f3_010", pc_src, 0);
    end
    bus.out_ready = 1'b1;
    drive(1'b1, mkctrl(1'b1, 1'b0, 3'b010), rnd_data());
    step();
    bus.out_ready = 1'b0;
    drive(1'b0, '0, '0);
    #1;
    chk("jump", pc_src, 1);
    check_all();
    bus.out_ready = 1'b1;
    step();
    {zero_e, lt_e, ltu_e} = 3'b111; #1;
    chk("stale_ctrl", pc_src, 0);
    check_all();

    // Randomized stream of 100 entries with random stalls
    n_in = 0; n_dut_out = 0;
    for (int cyc = 0; cyc < 4000 && n_in < 100; cyc++) begin
      if (n_in < 99) drive($urandom_range(0, 3) != 0, CTRL_W'($urandom()), rnd_data());
      else           drive($urandom_range(0, 1) != 0, CTRL_W'($urandom()), rnd_data());
      bus.out_ready = ($urandom_range(0, 9) < 6);
      {zero_e, lt_e, ltu_e} = 3'($urandom());
      step();
      check_all();
    end
    drive(1'b0, '0, '0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_all();
    end
    chk("stream_in", n_in, 100);
    chk("stream_out", n_dut_out, 100);

    // Reset while full discards both entries
    bus.out_ready = 1'b0;
    drive(1'b1, mkctrl(1'b1, 1'b0, 3'b000), rnd_data()); step();
    drive(1'b1, mkctrl(1'b1, 1'b0, 3'b000), rnd_data()); step();
    drive(1'b0, '0, '0);
    chk("pre_rst_occ", occupancy, 2);
    chk("pre_rst_pc_src", pc_src, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_occ", occupancy, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_pc_src", pc_src, 0);
    check_all();
    bus.out_ready = 1'b1;
    step();
    chk("post_rst_valid", bus.out_valid, 0);
    step();
    check_all();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter DATA_W, default 160, width of payload (PC, imm, PC+4, operands, register indices); payload is held, not cleared, on flush.
REQ-002 Parameter CTRL_W, default 16, minimum 5, width of control bundle; control is zeroed on flush and reset.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 flush  input  1  kill all held entries (bubble insertion).
REQ-006 in_valid  input  1  upstream (decode) entry present.
REQ-007 in_ready  output  1  stage can accept; registered, no combinational path from out_ready.
REQ-008 in_ctrl  input  CTRL_W  control bundle (RegWrite, MemWrite, Jump, Branch, funct3, ...).
REQ-009 in_data  input  DATA_W  payload.
REQ-010 out_valid  output  1  head entry valid toward execute.
REQ-011 out_ready  input  1  execute consumes head.
REQ-012 out_ctrl  output  CTRL_W  head control bundle.
REQ-013 out_data  output  DATA_W  head payload.
REQ-014 zero_e, lt_e, ltu_e  input  1 each  ALU flags: equal, signed less-than, unsigned less-than.
REQ-015 pc_src  output  1  redirect fetch (branch taken or jump).
REQ-016 occupancy  output  2  entries held, 0..2.

Function
REQ-017 Two entries: main (head, drives out_*) and skid; states EMPTY (0), ONE (main), FULL (main+skid); occupancy SHALL equal state count.
REQ-018 in_fire = in_valid & in_ready; out_fire = out_valid & out_ready; out_valid SHALL be 1 exactly when state != EMPTY.
REQ-019 in_ready SHALL be 1 exactly when state != FULL, taken from a register.
REQ-020 EMPTY: in_fire -> ONE, main <= input; else stay.
REQ-021 ONE: in_fire & out_fire -> ONE, main <= input; in_fire only -> FULL, skid <= input; out_fire only -> EMPTY; neither -> hold.
REQ-022 FULL: out_fire -> ONE, main <= skid; else hold (no input accepted).
REQ-023 Latency: accepted entry SHALL appear at out_* the cycle after in_fire when stage was empty or draining; ordering strictly FIFO.
REQ-024 Full throughput: with in_valid and out_ready held high, one entry per cycle, occupancy stays 1.
REQ-025 flush SHALL, next edge, force EMPTY, zero ctrl fields of both entries, leave data fields unchanged; a simultaneous in_valid entry is dropped; in_ready is 1 the cycle after.
REQ-026 Priority: rst > flush > handshake.
REQ-027 pc_src combinational: out_valid & (jump | (branch & take)); jump, branch, funct3 read from out_ctrl at package bit positions.
REQ-028 take by funct3: 000 zero_e; 001 !zero_e; 100 lt_e; 101 !lt_e; 110 ltu_e; 111 !ltu_e; 010/011 SHALL be 0.
REQ-029 pc_src SHALL be 0 whenever out_valid is 0, regardless of stale ctrl.

Reset
REQ-030 On rst: state EMPTY, occupancy 0, out_valid 0, in_ready 1, both ctrl fields 0, both data fields 0, pc_src 0.
REQ-031 rst mid-transfer SHALL discard both entries; no entry is emitted after reset.

Structure
REQ-032 Shared package pipe_pkg SHALL hold state enum, CTRL_JUMP_BIT, CTRL_BRANCH_BIT, CTRL_FUNCT3_LSB and funct3 branch encodings.
REQ-033 One sub-module branch_cond (funct3 + flags -> take), combinational, reusable by later stages.

Verification
REQ-034 Reset then in_valid=1 data=0x1000, out_ready=1 -> next cycle out_valid=1, out_data=0x1000, occupancy=1.
REQ-035 out_ready=0, push A then B -> occupancy=2, in_ready=0; out_ready=1 -> A then B emitted on consecutive cycles, in_ready=1 after A leaves.
REQ-036 FULL, flush=1 with in_valid=1 -> next cycle occupancy=0, out_valid=0, out_ctrl=0, dropped entry never appears.
REQ-037 Head branch funct3=101, lt_e=0 -> pc_src=1; lt_e=1 -> 0; funct3=010 any flags -> 0; jump=1 -> 1.
REQ-038 Stream 100 entries, random out_ready stalls -> output sequence equals input sequence, no loss, no duplication.
REQ-039 rst asserted while FULL -> next cycle occupancy=0, in_ready=1, pc_src=0.
